// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle control FSM and the LEGv8 datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_ctrl_if;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        IorD;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic        Reg2Loc;
    logic        RegWrite;
    logic        MemtoReg;
    logic        retire;
    logic        error;
    logic [3:0]  state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
               ALUOp, Reg2Loc, RegWrite, MemtoReg, retire, error, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
               ALUOp, Reg2Loc, RegWrite, MemtoReg, retire, error, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle LEGv8 core. It sequences the shared
// instruction/data memory, ALU, register file and PC through
// fetch/decode/execute/memory/writeback. Memory accesses use a
// mem_req/mem_ready handshake guarded by a wait-cycle timeout.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_MEM = 4'd7,
        WB_ALU = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        EXEC_I = 4'd11,
        ERROR  = 4'd15
    } state_t;

    // Outputs that depend on state alone.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       IorD;
        logic       PCSrc;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic       Reg2Loc;
        logic       RegWrite;
        logic       MemtoReg;
        logic       error;
    } moore_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    moore_t           mq;

    // State-only control decode; anything not set here stays 0.
    function automatic moore_t decode(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            FETCH:  begin m.mem_req = 1'b1; m.ALUSrcB = 2'b01; end
            DECODE: begin m.ALUSrcB = 2'b11; m.Reg2Loc = 1'b1; end
            EXEC_R: begin m.ALUSrcA = 1'b1; m.ALUOp = 2'b10; end
            EXEC_I: begin m.ALUSrcB = 2'b10; m.ALUOp = 2'b11; end
            ADDR:   begin m.ALUSrcA = 1'b1; m.ALUSrcB = 2'b10; m.Reg2Loc = 1'b1; end
            MEM_RD: begin m.mem_req = 1'b1; m.IorD = 1'b1; end
            MEM_WR: begin m.mem_req = 1'b1; m.mem_we = 1'b1; m.IorD = 1'b1; m.Reg2Loc = 1'b1; end
            WB_MEM: begin m.RegWrite = 1'b1; m.MemtoReg = 1'b1; end
            WB_ALU: begin m.RegWrite = 1'b1; end
            BRANCH: begin m.ALUSrcA = 1'b1; m.ALUOp = 2'b01; m.Reg2Loc = 1'b1; m.PCSrc = 1'b1; end
            JUMP:   begin m.PCSrc = 1'b1; end
            ERROR:  begin m.error = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Next-state and wait-counter logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH, MEM_RD, MEM_WR: begin
                if (bus.mem_ready) begin
                    // A response on the limit cycle still counts as a normal completion.
                    case (state_q)
                        FETCH:   state_d = DECODE;
                        MEM_RD:  state_d = WB_MEM;
                        default: state_d = FETCH;
                    endcase
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                casez (bus.opcode)
                    11'b10001011000, 11'b11001011000,
                    11'b10001010000, 11'b10101010000: state_d = EXEC_R;
                    11'b11111000010, 11'b11111000000: state_d = ADDR;
                    11'b10110100???:                  state_d = BRANCH;
                    11'b000101?????:                  state_d = JUMP;
                    11'b110100101??:                  state_d = EXEC_I;
                    default:                          state_d = ERROR;
                endcase
            end
            EXEC_R, EXEC_I: state_d = WB_ALU;
            ADDR: begin
                if (bus.opcode == OP_LDUR)      state_d = MEM_RD;
                else if (bus.opcode == OP_STUR) state_d = MEM_WR;
                else                            state_d = ERROR;
            end
            WB_MEM, WB_ALU, BRANCH, JUMP: state_d = FETCH;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
        // The wait count restarts whenever a memory-waiting state is newly entered.
        if (state_d != state_q &&
            (state_d == FETCH || state_d == MEM_RD || state_d == MEM_WR)) begin
            cnt_d = '0;
        end
    end

    // State, wait counter and registered Moore outputs.
    always_ff @(posedge CLK or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mq      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // NOTE: decoding the next state here gives glitch-free outputs that still line up with state_q.
            mq      <= decode(state_d);
        end
    end

    // Strobes that also depend on this cycle's inputs.
    assign bus.IRWrite = (state_q == FETCH) && bus.mem_ready;
    assign bus.PCWrite = ((state_q == FETCH) && bus.mem_ready) ||
                         ((state_q == BRANCH) && bus.zero) ||
                         (state_q == JUMP);
    assign bus.retire  = (state_q == WB_MEM) || (state_q == WB_ALU) ||
                         (state_q == BRANCH) || (state_q == JUMP) ||
                         ((state_q == MEM_WR) && bus.mem_ready);

    assign bus.mem_req  = mq.mem_req;
    assign bus.mem_we   = mq.mem_we;
    assign bus.IorD     = mq.IorD;
    assign bus.PCSrc    = mq.PCSrc;
    assign bus.ALUSrcA  = mq.ALUSrcA;
    assign bus.ALUSrcB  = mq.ALUSrcB;
    assign bus.ALUOp    = mq.ALUOp;
    assign bus.Reg2Loc  = mq.Reg2Loc;
    assign bus.RegWrite = mq.RegWrite;
    assign bus.MemtoReg = mq.MemtoReg;
    assign bus.error    = mq.error;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams, compared cycle by cycle against an instruction-level
// model of the expected state walk and control values.
module tb_multicycle_ctrl;

    logic CLK   = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       IorD;
        logic       IRWrite;
        logic       PCWrite;
        logic       PCSrc;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic       Reg2Loc;
        logic       RegWrite;
        logic       MemtoReg;
        logic       retire;
        logic       error;
    } ctl_t;

    typedef enum {I_ADD, I_SUB, I_AND, I_ORR, I_LDUR, I_STUR, I_CBZ, I_B, I_MOVZ, I_BAD} iclass_t;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_ADDR = 4,
                   S_MEM_RD = 5, S_MEM_WR = 6, S_WB_MEM = 7, S_WB_ALU = 8,
                   S_BRANCH = 9, S_JUMP = 10, S_EXEC_I = 11, S_ERROR = 15;

    // Expected control values for a state, straight from the control table.
    function automatic ctl_t exp_ctl(input int st, input bit rdy, input bit z);
        ctl_t c;
        c = '0;
        case (st)
            S_FETCH:  begin c.mem_req = 1; c.ALUSrcB = 2'b01; c.IRWrite = rdy; c.PCWrite = rdy; end
            S_DECODE: begin c.ALUSrcB = 2'b11; c.Reg2Loc = 1; end
            S_EXEC_R: begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
            S_EXEC_I: begin c.ALUSrcB = 2'b10; c.ALUOp = 2'b11; end
            S_ADDR:   begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.Reg2Loc = 1; end
            S_MEM_RD: begin c.mem_req = 1; c.IorD = 1; end
            S_MEM_WR: begin c.mem_req = 1; c.mem_we = 1; c.IorD = 1; c.Reg2Loc = 1; c.retire = rdy; end
            S_WB_MEM: begin c.RegWrite = 1; c.MemtoReg = 1; c.retire = 1; end
            S_WB_ALU: begin c.RegWrite = 1; c.retire = 1; end
            S_BRANCH: begin c.ALUSrcA = 1; c.ALUOp = 2'b01; c.Reg2Loc = 1; c.PCSrc = 1;
                            c.PCWrite = z; c.retire = 1; end
            S_JUMP:   begin c.PCSrc = 1; c.PCWrite = 1; c.retire = 1; end
            S_ERROR:  begin c.error = 1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c = {bus.mem_req, bus.mem_we, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.Reg2Loc, bus.RegWrite,
             bus.MemtoReg, bus.retire, bus.error};
        return c;
    endfunction

    function automatic logic [10:0] make_op(input iclass_t c);
        logic [10:0] r;
        r = 11'($urandom);
        case (c)
            I_ADD:   return 11'b10001011000;
            I_SUB:   return 11'b11001011000;
            I_AND:   return 11'b10001010000;
            I_ORR:   return 11'b10101010000;
            I_LDUR:  return 11'b11111000010;
            I_STUR:  return 11'b11111000000;
            I_CBZ:   return {8'b10110100, r[2:0]};
            I_B:     return {6'b000101, r[4:0]};
            I_MOVZ:  return {9'b110100101, r[1:0]};
            default: return 11'b11111111111;
        endcase
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, compare, then clock.
    task automatic step(input int st, input bit rdy, input bit z, input string tag);
        bus.mem_ready = rdy;
        bus.zero      = z;
        #1;
        check({tag, " state"}, 32'(bus.state), 32'(st));
        check({tag, " ctl"}, 32'(observed()), 32'(exp_ctl(st, rdy, z)));
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Whole instruction starting in FETCH: fw idle fetch cycles, mw idle memory cycles.
    task automatic run_instr(input iclass_t c, input int fw, input int mw, input bit z);
        bus.opcode = make_op(c);
        for (int k = 0; k <= fw; k++) step(S_FETCH, k == fw, rbit(), "fetch");
        step(S_DECODE, rbit(), rbit(), "decode");
        case (c)
            I_ADD, I_SUB, I_AND, I_ORR: begin
                step(S_EXEC_R, rbit(), rbit(), "exec_r");
                step(S_WB_ALU, rbit(), rbit(), "wb_alu");
            end
            I_MOVZ: begin
                step(S_EXEC_I, rbit(), rbit(), "exec_i");
                step(S_WB_ALU, rbit(), rbit(), "wb_alu");
            end
            I_LDUR: begin
                step(S_ADDR, rbit(), rbit(), "addr");
                for (int k = 0; k <= mw; k++) step(S_MEM_RD, k == mw, rbit(), "mem_rd");
                step(S_WB_MEM, rbit(), rbit(), "wb_mem");
            end
            I_STUR: begin
                step(S_ADDR, rbit(), rbit(), "addr");
                for (int k = 0; k <= mw; k++) step(S_MEM_WR, k == mw, rbit(), "mem_wr");
            end
            I_CBZ: step(S_BRANCH, rbit(), z, "branch");
            I_B:   step(S_JUMP, rbit(), rbit(), "jump");
            default: ;
        endcase
    endtask

    // Reset pulse from a falling edge; leaves the controller in FETCH.
    task automatic do_reset();
        reset         = 1'b1;
        bus.mem_ready = rbit();
        #1;
        check("reset state", 32'(bus.state), 32'(S_IDLE));
        check("reset ctl", 32'(observed()), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        step(S_IDLE, rbit(), rbit(), "idle");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        reset         = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        do_reset();

        // Zero-wait ADD twice: 0,1,2,3,8,1,... retire every 4th cycle.
        run_instr(I_ADD, 0, 0, 1'b0);
        run_instr(I_ADD, 0, 0, 1'b0);

        // LDUR with memory read answering on the 4th MEM_RD cycle.
        run_instr(I_LDUR, 0, 3, 1'b0);

        // CBZ taken and not taken.
        run_instr(I_CBZ, 0, 0, 1'b1);
        run_instr(I_CBZ, 0, 0, 1'b0);

        // Remaining classes at zero wait, plus a slow store.
        run_instr(I_B, 0, 0, 1'b0);
        run_instr(I_MOVZ, 0, 0, 1'b0);
        run_instr(I_STUR, 0, 0, 1'b0);
        run_instr(I_STUR, 2, 5, 1'b0);

        // Fetch answering on the last allowed wait cycle still advances.
        run_instr(I_SUB, 14, 0, 1'b0);

        // Illegal opcode: ERROR after DECODE, held with error=1 and no strobes.
        run_instr(I_BAD, 0, 0, 1'b0);
        for (int k = 0; k < 20; k++) step(S_ERROR, rbit(), rbit(), "illegal hold");
        do_reset();

        // Fetch timeout: 15 cycles without mem_ready, then ERROR.
        bus.opcode = make_op(I_ADD);
        for (int k = 0; k < 15; k++) step(S_FETCH, 1'b0, rbit(), "fetch wait");
        for (int k = 0; k < 5; k++) step(S_ERROR, rbit(), rbit(), "fetch timeout");
        do_reset();

        // Memory-read timeout behaves the same way.
        bus.opcode = make_op(I_LDUR);
        step(S_FETCH, 1'b1, 1'b0, "fetch");
        step(S_DECODE, 1'b0, 1'b0, "decode");
        step(S_ADDR, 1'b0, 1'b0, "addr");
        for (int k = 0; k < 15; k++) step(S_MEM_RD, 1'b0, rbit(), "mem_rd wait");
        step(S_ERROR, 1'b1, 1'b0, "mem_rd timeout");
        do_reset();

        // Reset during a store: strobes drop before the next rising edge.
        bus.opcode = make_op(I_STUR);
        step(S_FETCH, 1'b1, 1'b0, "fetch");
        step(S_DECODE, 1'b0, 1'b0, "decode");
        step(S_ADDR, 1'b0, 1'b0, "addr");
        bus.mem_ready = 1'b0;
        #1;
        check("mem_wr state", 32'(bus.state), 32'(S_MEM_WR));
        check("mem_wr req/we", 32'({bus.mem_req, bus.mem_we}), 32'b11);
        #1;
        reset = 1'b1;
        #1;
        check("abort state", 32'(bus.state), 32'(S_IDLE));
        check("abort req/we", 32'({bus.mem_req, bus.mem_we}), 32'b00);
        @(negedge CLK);
        reset = 1'b0;
        step(S_IDLE, 1'b0, 1'b0, "idle after abort");
        run_instr(I_ORR, 0, 0, 1'b0);

        // Random instruction stream with random memory latency.
        for (int n = 0; n < 60; n++) begin
            iclass_t c;
            c = iclass_t'($urandom_range(0, 8));
            run_instr(c, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), rbit());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
